uart_bus_ctrl: RTL and testbench
================================

Name: uart_bus_ctrl

Overview:
- CPU-side controller for the UART serial block. It is the bus end of the byte interface that the UART top exposes.
- Decodes three memory-mapped registers on the pipeline CPU's data-memory bus.
- Buffers outgoing bytes in a small TX FIFO and paces them into the sender using the TX_EN/TX_STATUS handshake.
- Holds each received byte in a status-flagged register until the CPU reads it, and raises an interrupt request.

Parameters:
- BASE_ADDR, 32'h40000018, byte address of TX data register. RX data is at BASE_ADDR+4; control/status is at BASE_ADDR+8.
- TX_DEPTH, 4, TX FIFO entries. Must be a power of two, at least 2.
- BUSY_TIMEOUT, 4, cycles to wait for TX_STATUS to fall after a launch before giving up.

Ports:
- sys_clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  CPU data-bus byte address.
- wdata  input  32  CPU write data.
- MemWrite  input  1  write strobe; single-cycle write.
- MemRead  input  1  read strobe.
- rdata  output  32  read data; combinational from addr.
- irq  output  1  level interrupt request.
- RX_DATA  input  8  received byte from UART receiver.
- RX_STATUS  input  1  one-cycle pulse: RX_DATA valid.
- TX_STATUS  input  1  high = sender idle and able to accept a byte.
- TX_DATA  output  8  byte to sender.
- TX_EN  output  1  one-cycle launch pulse to sender.

Behaviour:
- Reset values: TX_EN=0, TX_DATA=0, FIFO empty, FSM=IDLE, rx_buf=0, rx_valid=0, rx_overrun=0, tx_drop=0, rx_irq_en=0, tx_irq_en=0, irq=0.
- Address decode uses a full 32-bit compare. An unmatched address reads 0, and a write to it has no effect.
- Write to BASE_ADDR: push wdata[7:0] into the FIFO.
  - If the FIFO is full, the byte is discarded and tx_drop is set (sticky).
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Read of BASE_ADDR returns {24'b0, last pushed byte}. Reset value is 0.
- Read of BASE_ADDR+4 returns {24'b0, rx_buf}. When MemRead is high for this address, rx_valid clears at the clock edge.
- Control/status read at BASE_ADDR+8 returns:
  - [0] fifo_full
  - [1] fifo_empty
  - [2] rx_valid
  - [3] rx_overrun
  - [4] tx_busy (FSM!=IDLE or FIFO not empty)
  - [5] tx_drop
  - [6] rx_irq_en
  - [7] tx_irq_en
  - [10:8] fifo count (zero-extended or truncated to 3 bits)
  - other bits 0
- Control/status write at BASE_ADDR+8:
  - bit0 loads rx_irq_en; bit1 loads tx_irq_en.
  - bit2=1 clears rx_overrun; bit3=1 clears tx_drop.
  - Writing 0 to bit2 or bit3 has no effect.
- RX capture:
  - On RX_STATUS=1, RX_DATA is latched into rx_buf and rx_valid is set.
  - If rx_valid was already 1 and no RX-data read happens in the same cycle, rx_overrun is set and the new byte overwrites the old.
  - RX_STATUS together with an RX-data read: rdata returns the old byte, the new byte is latched, rx_valid stays 1, no overrun.
- TX FSM states are IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE.
  - IDLE: if FIFO non-empty and TX_STATUS=1, go to LAUNCH.
  - LAUNCH (1 cycle): TX_EN=1, TX_DATA=FIFO head, pop; go to WAIT_BUSY.
  - WAIT_BUSY: if TX_STATUS=0, go to WAIT_IDLE. After BUSY_TIMEOUT cycles with TX_STATUS still 1, go to IDLE (byte treated as sent).
  - WAIT_IDLE: when TX_STATUS=1, go to IDLE.
  - TX_DATA holds its value outside LAUNCH. TX_EN is high only in LAUNCH.
  - Minimum byte-to-byte launch spacing is 4 cycles.
- irq = (rx_irq_en & rx_valid) | (tx_irq_en & fifo_empty & FSM==IDLE). Registered; it updates one cycle after its cause.
- A write arriving while the FSM is mid-transfer only enqueues; the in-flight byte is unaffected.
- Reset asserted mid-transfer clears all state immediately; TX_EN drops asynchronously. A byte already launched into the sender is not recalled.

Test Plan:
- Reset, then read BASE_ADDR+8 -> rdata=32'h00000002 (empty only); TX_EN=0; irq=0.
- TX_STATUS held 1 (model sender drops it for 10 cycles after TX_EN), write 8'h55 to BASE_ADDR -> TX_EN pulses once with TX_DATA=8'h55 two cycles after the write; FIFO empty after the pop.
- Four quick writes 8'h01..8'h04, then a fifth write 8'h05 while the FIFO is full -> 01..04 launched in order, one per sender idle period; 05 never launched; status bit5=1; writing 0x8 clears it.
- RX_STATUS pulse with 8'hA3, then read BASE_ADDR+4 -> rdata=32'hA3; status bit2 goes 1 then 0. Two pulses (8'h11, 8'h22) with no read -> rx_buf=8'h22, bit3=1; writing 0x4 clears bit3.
- rx_irq_en=1, RX pulse -> irq=1 the next cycle; RX-data read -> irq=0 one cycle later. tx_irq_en=1 with the FIFO drained and FSM idle -> irq=1.
- Sender model never lowers TX_STATUS -> FSM returns to IDLE after BUSY_TIMEOUT=4 cycles and launches the next FIFO byte.
- Reset asserted during WAIT_IDLE with 2 bytes queued -> FIFO empty, TX_EN=0, no further launches.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// Bus-side controller for the UART byte interface: three memory-mapped registers,
// a TX FIFO paced into the sender by a small handshake FSM, and a flagged RX holding register.
module uart_bus_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000018,
  parameter int          TX_DEPTH     = 4,
  parameter int          BUSY_TIMEOUT = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STATUS,
  input  logic        TX_STATUS,
  output logic [7:0]  TX_DATA,
  output logic        TX_EN
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } tx_state_t;

  tx_state_t      r_state;
  logic [7:0]     r_fifo [TX_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [TW-1:0]  r_busy_cnt;
  logic [7:0]     r_last_tx;
  logic [7:0]     r_tx_data;
  logic           r_tx_en;
  logic [7:0]     r_rx_buf;
  logic           r_rx_valid;
  logic           r_rx_overrun;
  logic           r_tx_drop;
  logic           r_rx_irq_en;
  logic           r_tx_irq_en;
  logic           r_irq;

  logic           w_tx_sel;
  logic           w_rx_sel;
  logic           w_cs_sel;
  logic           w_full;
  logic           w_empty;
  logic           w_push_req;
  logic           w_push;
  logic           w_pop;
  logic           w_rx_read;
  logic           w_cs_wr;
  logic           w_tx_busy;
  logic [2:0]     w_count3;
  logic [31:0]    w_status;
  logic           w_unused;

  assign w_tx_sel   = (addr == BASE_ADDR);
  assign w_rx_sel   = (addr == BASE_ADDR + 32'd4);
  assign w_cs_sel   = (addr == BASE_ADDR + 32'd8);
  assign w_full     = (r_count == CW'(TX_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = MemWrite & w_tx_sel;
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == LAUNCH);
  assign w_rx_read  = MemRead & w_rx_sel;
  assign w_cs_wr    = MemWrite & w_cs_sel;
  assign w_tx_busy  = (r_state != IDLE) | ~w_empty;
  assign w_unused   = ^wdata[31:8];

  generate
    if (CW >= 3) begin : g_cnt_trunc
      assign w_count3 = r_count[2:0];
    end else begin : g_cnt_ext
      assign w_count3 = {{(3-CW){1'b0}}, r_count};
    end
  endgenerate

  assign w_status = {21'b0, w_count3, r_tx_irq_en, r_rx_irq_en, r_tx_drop, w_tx_busy,
                     r_rx_overrun, r_rx_valid, w_empty, w_full};

  always_comb begin
    rdata = 32'b0;
    if (w_tx_sel)      rdata = {24'b0, r_last_tx};
    else if (w_rx_sel) rdata = {24'b0, r_rx_buf};
    else if (w_cs_sel) rdata = w_status;
  end

  // Storage carries no reset so it can map onto plain RAM; only pointers and count are cleared.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_tx <= 8'h00;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_last_tx <= wdata[7:0];
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_cs_wr && wdata[3]) r_tx_drop <= 1'b0;
      if (w_push_req && w_full) r_tx_drop <= 1'b1;
    end
  end

  // TX_EN and TX_DATA are loaded on the IDLE->LAUNCH edge so they are valid exactly during LAUNCH.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_en    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy_cnt <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty && TX_STATUS) begin
            r_state   <= LAUNCH;
            r_tx_en   <= 1'b1;
            r_tx_data <= r_fifo[r_rd_ptr];
          end
        end
        LAUNCH: begin
          r_state    <= WAIT_BUSY;
          r_busy_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (!TX_STATUS)
            r_state <= WAIT_IDLE;
          else if (r_busy_cnt == TW'(BUSY_TIMEOUT - 1))
            r_state <= IDLE;
          else
            r_busy_cnt <= r_busy_cnt + TW'(1);
        end
        WAIT_IDLE: begin
          if (TX_STATUS) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_rx_buf     <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_irq_en  <= 1'b0;
      r_tx_irq_en  <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_cs_wr) begin
        r_rx_irq_en <= wdata[0];
        r_tx_irq_en <= wdata[1];
        if (wdata[2]) r_rx_overrun <= 1'b0;
      end
      // A new byte arriving alongside a data read replaces the one being read without overrun.
      if (RX_STATUS) begin
        r_rx_buf   <= RX_DATA;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !w_rx_read) r_rx_overrun <= 1'b1;
      end else if (w_rx_read) begin
        r_rx_valid <= 1'b0;
      end
      r_irq <= (r_rx_irq_en & r_rx_valid) | (r_tx_irq_en & w_empty & (r_state == IDLE));
    end
  end

  assign TX_EN   = r_tx_en;
  assign TX_DATA = r_tx_data;
  assign irq     = r_irq;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl with a simple sender model and a launch logger.
module tb_uart_bus_ctrl;

  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] TXA  = BASE;
  localparam logic [31:0] RXA  = BASE + 32'd4;
  localparam logic [31:0] CSA  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  RX_DATA;
  logic        RX_STATUS;
  logic        TX_STATUS;
  logic [7:0]  TX_DATA;
  logic        TX_EN;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  launches[$];
  int          launch_cyc[$];
  int          sender_busy = 0;
  logic        hold = 1'b0;
  logic        stuck = 1'b0;
  logic [31:0] d;

  always #5 clk = ~clk;

  uart_bus_ctrl dut (
    .sys_clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .rdata(rdata), .irq(irq),
    .RX_DATA(RX_DATA), .RX_STATUS(RX_STATUS), .TX_STATUS(TX_STATUS),
    .TX_DATA(TX_DATA), .TX_EN(TX_EN)
  );

  // Sender model: busy for 10 cycles after each launch unless stuck idle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (TX_EN && !stuck) sender_busy <= 10;
    else if (sender_busy != 0) sender_busy <= sender_busy - 1;
  end
  assign TX_STATUS = stuck ? 1'b1 : (!hold && sender_busy == 0);

  always @(negedge clk) begin
    if (TX_EN === 1'b1) begin
      launches.push_back(TX_DATA);
      launch_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr = a; wdata = v; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; MemRead = 1'b1;
    #1 v = rdata;
    tick();
    MemRead = 1'b0; addr = 32'h0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a;
    #1 v = rdata;
    addr = 32'h0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    RX_DATA = b; RX_STATUS = 1'b1;
    tick();
    RX_STATUS = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 0; wdata = 0; MemWrite = 0; MemRead = 0;
    RX_DATA = 0; RX_STATUS = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    peek(CSA, d);  check("rst_status", d, 32'h2);
    peek(TXA, d);  check("rst_txreg", d, 32'h0);
    peek(RXA, d);  check("rst_rxreg", d, 32'h0);
    check("rst_txen", {31'b0, TX_EN}, 32'h0);
    check("rst_txdata", {24'b0, TX_DATA}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    peek(BASE + 32'd12, d); check("unmapped_rd", d, 32'h0);
    wr(BASE - 32'd4, 32'hFF);
    peek(CSA, d);  check("unmapped_wr", d, 32'h2);

    // Single byte: launch two cycles after the write
    tick();
    wr(TXA, 32'h55);
    check("tx1_early", {31'b0, TX_EN}, 32'h0);
    tick();
    check("tx1_en", {31'b0, TX_EN}, 32'h1);
    check("tx1_data", {24'b0, TX_DATA}, 32'h55);
    tick();
    check("tx1_en_drop", {31'b0, TX_EN}, 32'h0);
    peek(CSA, d);  check("tx1_status", d, 32'h12);
    repeat (20) tick();
    check("tx1_count", launches.size(), 1);
    check("tx1_hold", {24'b0, TX_DATA}, 32'h55);
    launches.delete(); launch_cyc.delete();

    // Fill FIFO while sender held busy, then overflow
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) wr(TXA, i);
    peek(CSA, d);  check("full_status", d, 32'h431);
    peek(TXA, d);  check("last_pushed", d, 32'h04);
    hold = 1'b0;
    repeat (80) tick();
    check("fifo_launch_cnt", launches.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (i < launches.size()) ? launches[i] : 8'hxx;
      check($sformatf("fifo_order%0d", i), {24'b0, got}, i + 1);
    end
    peek(CSA, d);  check("drop_sticky", d, 32'h22);
    wr(CSA, 32'h8);
    peek(CSA, d);  check("drop_clear", d, 32'h2);
    launches.delete(); launch_cyc.delete();

    // RX capture, read, overrun
    rx_pulse(8'hA3);
    peek(CSA, d);  check("rx_valid_set", d, 32'h6);
    rd(RXA, d);    check("rx_data", d, 32'hA3);
    peek(CSA, d);  check("rx_valid_clr", d, 32'h2);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    peek(CSA, d);  check("rx_overrun", d, 32'hE);
    peek(RXA, d);  check("rx_overwrite", d, 32'h22);
    wr(CSA, 32'h4);
    peek(CSA, d);  check("ovr_clear", d, 32'h6);
    addr = RXA; MemRead = 1'b1; RX_DATA = 8'h44; RX_STATUS = 1'b1;
    #1 d = rdata;
    tick();
    MemRead = 1'b0; RX_STATUS = 1'b0; addr = 0;
    check("rx_rd_same_old", d, 32'h22);
    peek(CSA, d);  check("rx_rd_same_st", d, 32'h6);
    peek(RXA, d);  check("rx_rd_same_new", d, 32'h44);
    rd(RXA, d);
    peek(CSA, d);  check("rx_final_st", d, 32'h2);

    // Interrupts
    tick();
    wr(CSA, 32'h1);
    peek(CSA, d);  check("rx_irq_en", d, 32'h42);
    tick();
    rx_pulse(8'h5A);
    check("irq_rx_lat", {31'b0, irq}, 32'h0);
    tick();
    check("irq_rx_on", {31'b0, irq}, 32'h1);
    rd(RXA, d);    check("irq_rx_data", d, 32'h5A);
    check("irq_rx_hold", {31'b0, irq}, 32'h1);
    tick();
    check("irq_rx_off", {31'b0, irq}, 32'h0);
    wr(CSA, 32'h2);
    check("irq_tx_lat", {31'b0, irq}, 32'h0);
    tick();
    check("irq_tx_on", {31'b0, irq}, 32'h1);
    wr(CSA, 32'h0);
    repeat (2) tick();
    check("irq_off", {31'b0, irq}, 32'h0);

    // Sender never lowers TX_STATUS: timeout then next launch
    stuck = 1'b1;
    wr(TXA, 32'h71);
    wr(TXA, 32'h72);
    repeat (15) tick();
    check("tmo_cnt", launches.size(), 2);
    if (launches.size() == 2) begin
      check("tmo_b0", {24'b0, launches[0]}, 32'h71);
      check("tmo_b1", {24'b0, launches[1]}, 32'h72);
      check("tmo_gap", launch_cyc[1] - launch_cyc[0], 6);
    end
    stuck = 1'b0;
    repeat (5) tick();
    launches.delete(); launch_cyc.delete();

    // Reset during WAIT_IDLE with two bytes queued
    wr(TXA, 32'h81);
    wr(TXA, 32'h82);
    wr(TXA, 32'h83);
    repeat (3) tick();
    peek(CSA, d);  check("pre_rst_status", d, 32'h210);
    check("pre_rst_launch", launches.size(), 1);
    launches.delete(); launch_cyc.delete();
    reset = 1'b1;
    #1;
    check("rst_mid_txen", {31'b0, TX_EN}, 32'h0);
    peek(CSA, d);  check("rst_mid_status", d, 32'h2);
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check("rst_no_launch", launches.size(), 0);
    peek(CSA, d);  check("rst_post_status", d, 32'h2);
    check("rst_post_irq", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
